// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - shared widths, entry type, flag codes and FSM states for carry_bitstream_unpacker
package bs_pkg;

    localparam int BS_BITSTREAM_WIDTH = 8;
    localparam int BS_FLAG_WIDTH      = 3;

    typedef logic [BS_BITSTREAM_WIDTH-1:0] bs_byte_t;
    typedef logic [BS_FLAG_WIDTH-1:0]      bs_flag_t;

    localparam bs_flag_t FLAG_NONE      = bs_flag_t'(0);
    localparam bs_flag_t FLAG_1B        = bs_flag_t'(1);
    localparam bs_flag_t FLAG_2B        = bs_flag_t'(2);
    localparam bs_flag_t FLAG_3B        = bs_flag_t'(3);
    localparam bs_flag_t FLAG_4B        = bs_flag_t'(4);
    localparam bs_flag_t FLAG_RUN       = bs_flag_t'(5);
    localparam bs_flag_t FLAG_RUN_B4    = bs_flag_t'(6);
    localparam bs_flag_t FLAG_RUN_B4_B5 = bs_flag_t'(7);

    typedef struct packed {
        bs_flag_t flag;
        bs_byte_t bit1;
        bs_byte_t bit2;
        bs_byte_t bit3;
        bs_byte_t bit4;
        bs_byte_t bit5;
        logic     last;
    } bs_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_B1,
        EMIT_RUN,
        EMIT_B4,
        EMIT_B5,
        EMIT_SEQ
    } bs_state_t;

endpackage

// File: rtl/carry_bitstream_unpacker_if.sv
// rtl/carry_bitstream_unpacker_if.sv - serialized byte stream with valid/ready handshake
interface carry_bitstream_unpacker_if;
    import bs_pkg::*;

    logic [BS_BITSTREAM_WIDTH-1:0] out_byte;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;

    modport master (output out_byte, output out_valid, output out_last, input out_ready);
    modport slave  (input out_byte, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/bs_entry_fifo.sv
// rtl/bs_entry_fifo.sv - synchronous FIFO of bs_entry_t, first-word visible on dout
module bs_entry_fifo
    import bs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  bs_entry_t din,
    input  logic      pop,
    output bs_entry_t dout,
    output logic      full,
    output logic      empty
);

    bs_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/carry_bitstream_unpacker.sv
// rtl/carry_bitstream_unpacker.sv - expands stage_4 flag entries into a byte stream; BS_BYTE_COUNT_EN adds out_byte_count
module carry_bitstream_unpacker
    import bs_pkg::*;
#(
    parameter int BS_FIFO_DEPTH = 8,
    parameter int BS_PTR_WIDTH  = 3
) (
    input  logic                          bs_clk,
    input  logic                          bs_reset,
    input  logic [BS_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
    input  logic [BS_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
    input  logic [BS_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
    input  logic [BS_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
    input  logic [BS_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
    input  logic [BS_FLAG_WIDTH-1:0]      in_carry_flag,
    input  logic                          in_flag_last,
    carry_bitstream_unpacker_if.master    out_if,
    output logic                          out_overflow
`ifdef BS_BYTE_COUNT_EN
    ,
    output logic [31:0]                   out_byte_count
`endif
);

    bs_entry_t in_entry, fifo_head, src_entry;
    bs_entry_t hold_q, hold_d, nhold;
    bs_state_t state_q, state_d, nstate;
    bs_flag_t  idx_q, idx_d, nidx;
    bs_byte_t  run_q, run_d, nrun;
    bs_byte_t  out_byte_q, out_byte_d, nbyte;
    logic      out_valid_q, out_valid_d;
    logic      out_last_q, out_last_d;
    logic      overflow_q, overflow_d;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      in_valid, xfer, advance, take, nfinal;

    assign in_entry = '{flag: in_carry_flag, bit1: in_carry_bit_1, bit2: in_carry_bit_2,
                        bit3: in_carry_bit_3, bit4: in_carry_bit_4, bit5: in_carry_bit_5,
                        last: in_flag_last};
    assign in_valid  = (in_carry_flag != FLAG_NONE);
    assign xfer      = out_valid_q && out_if.out_ready;
    assign advance   = (state_q == IDLE) || xfer;
    // An empty FIFO lets the live input bypass straight into the holding register.
    assign src_entry = fifo_empty ? in_entry : fifo_head;

    always_comb begin
        nstate = IDLE;
        nidx   = idx_q;
        nrun   = run_q;
        nhold  = hold_q;
        take   = 1'b0;
        case (state_q)
            EMIT_B1: begin
                if (hold_q.flag inside {FLAG_2B, FLAG_3B, FLAG_4B}) begin
                    nstate = EMIT_SEQ;
                    nidx   = FLAG_2B;
                end else if (hold_q.flag >= FLAG_RUN) begin
                    if (hold_q.bit3 != '0) begin
                        nstate = EMIT_RUN;
                        nrun   = hold_q.bit3;
                    end else if (hold_q.flag != FLAG_RUN) begin
                        nstate = EMIT_B4;
                    end
                end
            end
            EMIT_SEQ: begin
                if (idx_q < hold_q.flag) begin
                    nstate = EMIT_SEQ;
                    nidx   = idx_q + 1'b1;
                end
            end
            EMIT_RUN: begin
                if (run_q > 8'd1) begin
                    nstate = EMIT_RUN;
                    nrun   = run_q - 8'd1;
                end else if (hold_q.flag != FLAG_RUN) begin
                    nstate = EMIT_B4;
                end
            end
            EMIT_B4: begin
                if (hold_q.flag == FLAG_RUN_B4_B5) begin
                    nstate = EMIT_B5;
                end
            end
            default: nstate = IDLE;
        endcase

        if (advance && (nstate == IDLE) && (in_valid || !fifo_empty)) begin
            take   = 1'b1;
            nhold  = src_entry;
            nstate = (src_entry.flag == FLAG_NONE) ? IDLE : EMIT_B1;
        end

        nbyte  = '0;
        nfinal = 1'b0;
        case (nstate)
            EMIT_B1: begin
                nbyte  = nhold.bit1;
                nfinal = (nhold.flag == FLAG_1B) || ((nhold.flag == FLAG_RUN) && (nhold.bit3 == '0));
            end
            EMIT_SEQ: begin
                nbyte  = (nidx == FLAG_2B) ? nhold.bit2 : (nidx == FLAG_3B) ? nhold.bit3 : nhold.bit4;
                nfinal = (nidx == nhold.flag);
            end
            EMIT_RUN: begin
                nbyte  = nhold.bit2;
                nfinal = (nrun == 8'd1) && (nhold.flag == FLAG_RUN);
            end
            EMIT_B4: begin
                nbyte  = nhold.bit4;
                nfinal = (nhold.flag == FLAG_RUN_B4);
            end
            EMIT_B5: begin
                nbyte  = nhold.bit5;
                nfinal = 1'b1;
            end
            default: begin
                nbyte  = '0;
                nfinal = 1'b0;
            end
        endcase

        state_d     = state_q;
        idx_d       = idx_q;
        run_d       = run_q;
        hold_d      = hold_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (advance) begin
            state_d     = nstate;
            idx_d       = nidx;
            run_d       = nrun;
            hold_d      = nhold;
            out_byte_d  = nbyte;
            out_valid_d = (nstate != IDLE);
            out_last_d  = nfinal && nhold.last;
        end
    end

    always_comb begin
        fifo_pop   = take && !fifo_empty;
        fifo_push  = in_valid && !(take && fifo_empty) && (!fifo_full || fifo_pop);
        overflow_d = overflow_q || (in_valid && fifo_full && !fifo_pop);
    end

    bs_entry_fifo #(
        .DEPTH (BS_FIFO_DEPTH),
        .PTR_W (BS_PTR_WIDTH)
    ) u_fifo (
        .clk   (bs_clk),
        .rst_n (bs_reset),
        .push  (fifo_push),
        .din   (in_entry),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge bs_clk or negedge bs_reset) begin
        if (!bs_reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            run_q       <= '0;
            hold_q      <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            hold_q      <= hold_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_if.out_byte  = out_byte_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign out_overflow     = overflow_q;

`ifdef BS_BYTE_COUNT_EN
    logic [31:0] byte_count_q, byte_count_d;
    logic        count_clr_q, count_clr_d;

    always_comb begin
        count_clr_d  = xfer && out_last_q;
        byte_count_d = (count_clr_q ? 32'd0 : byte_count_q) + {31'd0, xfer};
    end

    always_ff @(posedge bs_clk or negedge bs_reset) begin
        if (!bs_reset) begin
            byte_count_q <= '0;
            count_clr_q  <= 1'b0;
        end else begin
            byte_count_q <= byte_count_d;
            count_clr_q  <= count_clr_d;
        end
    end

    assign out_byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_carry_bitstream_unpacker.sv
// tb/tb_carry_bitstream_unpacker.sv - directed and randomized checks of carry_bitstream_unpacker
module tb_carry_bitstream_unpacker;

    logic       bs_clk = 1'b0;
    logic       bs_reset;
    logic [7:0] b1, b2, b3, b4, b5;
    logic [2:0] flag;
    logic       flag_last;
    logic       overflow;
`ifdef BS_BYTE_COUNT_EN
    logic [31:0] byte_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_b[$];
    logic       exp_l[$];
    logic [7:0] got_b[$];
    logic       got_l[$];

    carry_bitstream_unpacker_if bus ();

    carry_bitstream_unpacker dut (
        .bs_clk         (bs_clk),
        .bs_reset       (bs_reset),
        .in_carry_bit_1 (b1),
        .in_carry_bit_2 (b2),
        .in_carry_bit_3 (b3),
        .in_carry_bit_4 (b4),
        .in_carry_bit_5 (b5),
        .in_carry_flag  (flag),
        .in_flag_last   (flag_last),
        .out_if         (bus),
        .out_overflow   (overflow)
`ifdef BS_BYTE_COUNT_EN
        ,
        .out_byte_count (byte_count)
`endif
    );

    always #5 bs_clk = ~bs_clk;

    always @(negedge bs_clk) begin
        if (bs_reset && bus.out_valid && bus.out_ready) begin
            got_b.push_back(bus.out_byte);
            got_l.push_back(bus.out_last);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference expansion written straight from the flag rules.
    function automatic void expand(input logic [2:0] f, input logic [7:0] a1, input logic [7:0] a2,
                                   input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
                                   input logic l);
        logic [7:0] lane [5];
        lane[0] = a1; lane[1] = a2; lane[2] = a3; lane[3] = a4; lane[4] = a5;
        exp_b.push_back(a1);
        if (f >= 3'd2 && f <= 3'd4) begin
            for (int k = 2; k <= int'(f); k++) exp_b.push_back(lane[k-1]);
        end
        if (f >= 3'd5) begin
            for (int k = 0; k < int'(a3); k++) exp_b.push_back(a2);
            if (f >= 3'd6) exp_b.push_back(a4);
            if (f == 3'd7) exp_b.push_back(a5);
        end
        while (exp_l.size() < exp_b.size()) exp_l.push_back(1'b0);
        exp_l[exp_l.size()-1] = l;
    endfunction

    task automatic push(input logic [2:0] f, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
                        input logic l, input bit model);
        flag = f; b1 = a1; b2 = a2; b3 = a3; b4 = a4; b5 = a5; flag_last = l;
        @(posedge bs_clk);
        #1;
        flag = 3'd0;
        if (model) expand(f, a1, a2, a3, a4, a5, l);
    endtask

    task automatic drain(input string tag, input bit rand_ready);
        int n = 0;
        while (got_b.size() < exp_b.size() && n < 5000) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge bs_clk);
            #1;
            n++;
        end
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(posedge bs_clk);
            #1;
        end
        check({tag, "_len"}, 64'(got_b.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {got_l[i], got_b[i]}, {exp_l[i], exp_b[i]});
        got_b.delete(); got_l.delete(); exp_b.delete(); exp_l.delete();
    endtask

    initial begin
        logic [2:0] rf;
        logic [7:0] r3;
        int         n;

        bs_reset = 1'b0;
        flag = 3'd0; flag_last = 1'b0;
        b1 = 8'd0; b2 = 8'd0; b3 = 8'd0; b4 = 8'd0; b5 = 8'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge bs_clk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_byte", bus.out_byte, 8'h00);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        bs_reset = 1'b1;
        @(posedge bs_clk);
        #1;

        push(3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b0, 1'b1);
        check("f3_cyc1", {bus.out_valid, bus.out_last, bus.out_byte}, {1'b1, 1'b0, 8'h11});
        @(posedge bs_clk); #1;
        check("f3_cyc2", {bus.out_valid, bus.out_last, bus.out_byte}, {1'b1, 1'b0, 8'h22});
        @(posedge bs_clk); #1;
        check("f3_cyc3", {bus.out_valid, bus.out_last, bus.out_byte}, {1'b1, 1'b0, 8'h33});
        @(posedge bs_clk); #1;
        check("f3_idle", bus.out_valid, 1'b0);
        drain("f3", 1'b0);

        push(3'd7, 8'h10, 8'hFF, 8'd3, 8'h40, 8'h50, 1'b0, 1'b1);
        drain("f7_run3", 1'b0);
        push(3'd7, 8'h10, 8'hFF, 8'd0, 8'h40, 8'h50, 1'b0, 1'b1);
        drain("f7_run0", 1'b0);

        bus.out_ready = 1'b0;
        push(3'd2, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_hold%0d", i), {bus.out_valid, bus.out_byte}, {1'b1, 8'hAA});
            @(posedge bs_clk); #1;
        end
        drain("f2_stall", 1'b0);

        push(3'd4, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 1'b1, 1'b1);
`ifdef BS_BYTE_COUNT_EN
        repeat (4) @(posedge bs_clk);
        #1;
        check("bcnt_four", byte_count, 32'd4);
        @(posedge bs_clk); #1;
        check("bcnt_clear", byte_count, 32'd0);
`endif
        drain("f4_last", 1'b0);

        for (int burst = 0; burst < 6; burst++) begin
            n = int'($urandom_range(1, 8));
            for (int j = 0; j < n; j++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                rf = 3'($urandom_range(1, 7));
                r3 = (rf >= 3'd5) ? 8'($urandom_range(0, 6)) : 8'($urandom);
                push(rf, 8'($urandom), 8'($urandom), r3, 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)), 1'b1);
            end
            drain($sformatf("rand%0d", burst), 1'b1);
        end
        check("rand_no_ovf", overflow, 1'b0);

        push(3'd5, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            push(3'd1, 8'(i + 1), 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        check("ovf_full_ok", overflow, 1'b0);
        push(3'd1, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        check("ovf_set", overflow, 1'b1);
        drain("ovf_order", 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        push(3'd5, 8'h01, 8'h02, 8'd100, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (10) @(posedge bs_clk);
        #3;
        bs_reset = 1'b0;
        #1;
        check("midrst_valid", bus.out_valid, 1'b0);
        check("midrst_byte", bus.out_byte, 8'h00);
        check("midrst_last", bus.out_last, 1'b0);
        check("midrst_ovf", overflow, 1'b0);
        @(posedge bs_clk); #1;
        bs_reset = 1'b1;
        got_b.delete(); got_l.delete(); exp_b.delete(); exp_l.delete();
        push(3'd3, 8'h71, 8'h72, 8'h73, 8'h00, 8'h00, 1'b1, 1'b1);
        drain("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry_bitstream_unpacker.md
Name: carry_bitstream_unpacker

Overview:
- Consumes the flag-encoded, multi-byte output of stage_4 (carry propagation) and serializes it into a plain byte stream, one byte per cycle.
- Output uses a valid/ready handshake toward the bitstream writer/AXI side.
- Stage_4 has no backpressure, so an entry FIFO absorbs bursts and run-length expansion.
- Sits directly after stage_4 in the arithmetic-encoder top.

Parameters:
- BS_BITSTREAM_WIDTH, 8, byte width of every carry_bit lane and of out_byte.
- BS_FLAG_WIDTH, 3, width of the stage_4 bitstream flag.
- BS_FIFO_DEPTH, 8, entry FIFO depth in entries; power of 2, minimum 2.
- BS_PTR_WIDTH, 3, log2(BS_FIFO_DEPTH).

Ports:
- bs_clk  in  1  clock.
- bs_reset  in  1  asynchronous, active-low reset.
- in_carry_bit_1 .. in_carry_bit_5  in  BS_BITSTREAM_WIDTH each  stage_4 out_carry_bit_1..5.
- in_carry_flag  in  BS_FLAG_WIDTH  stage_4 out_carry_flag_bitstream; 0 = no data.
- in_flag_last  in  1  stage_4 output_flag_last; marks the final entry of a frame.
- out_byte  out  BS_BITSTREAM_WIDTH  serialized byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  qualifies the final byte of a frame.
- out_overflow  out  1  sticky: an entry was dropped.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM in IDLE; out_byte=0, out_valid=0, out_last=0, out_overflow=0.
- Push side:
  - Every cycle with in_carry_flag!=0, push {flag, bit1..bit5, last} as one entry.
  - Flag values 1..7 are valid. No input stall exists.
  - If the FIFO is full and no pop happens in the same cycle, drop the entry and set out_overflow. out_overflow stays set until reset.
  - Simultaneous push and pop on a full FIFO is allowed and does not overflow.
- Expansion order per flag:
  - 1: b1.
  - 2: b1, b2.
  - 3: b1, b2, b3.
  - 4: b1, b2, b3, b4.
  - 5: b1, then b2 repeated b3 times.
  - 6: as flag 5, then b4.
  - 7: as flag 5, then b4, then b5.
  - For flags 5–7, b3 is an unsigned repeat count; b3=0 emits no b2 bytes.
- FSM states: IDLE, EMIT_B1, EMIT_RUN, EMIT_B4, EMIT_B5, EMIT_SEQ (flags 2–4 tail).
  - IDLE: when the FIFO is non-empty, pop into a holding register and go to EMIT_B1.
  - EMIT_B1: drive b1.
  - EMIT_SEQ: walks lane index 2..flag.
  - EMIT_RUN: decrements an 8-bit run counter loaded from b3.
- Handshake:
  - A byte transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_byte and out_last hold stable.
  - A state advances only on a transfer.
  - On the transfer of an entry's final byte, the next FIFO entry, if present, is popped in the same cycle. This gives zero bubble between entries.
- Latency: a push into an empty, idle block gives out_valid on the next cycle (1-cycle latency).
- out_last = 1 only on the final byte of an entry whose last bit was 1.
- Reset mid-expansion abandons the current entry and all FIFO contents.
- Illegal flag is impossible in the flag width; the FSM treats flag 0 in the holding register as a no-op and returns to IDLE.

Optional Feature:
- BS_BYTE_COUNT_EN.
- Defined: adds output port out_byte_count (32 bits).
  - Increments on every output transfer and wraps at 2^32.
  - Clears on reset and on the cycle after a transfer with out_last=1.
- Undefined: no port and no counter logic.

Decomposition:
- Package bs_pkg holds:
  - typedef bs_entry_t struct {flag, bit1..bit5, last}.
  - localparams for flag codes FLAG_NONE, FLAG_1B to FLAG_4B, FLAG_RUN, FLAG_RUN_B4, FLAG_RUN_B4_B5.
  - typedef enum for the FSM states.
- One sub-module, bs_entry_fifo: a synchronous FIFO of bs_entry_t with push, pop, full, empty and the same async active-low reset.

Test Plan:
- Flag 3 {0x11, 0x22, 0x33}, out_ready=1 -> bytes 0x11, 0x22, 0x33 on 3 consecutive cycles starting 1 cycle after push.
- Flag 7 {0x10, 0xFF, 3, 0x40, 0x50} -> 0x10, 0xFF, 0xFF, 0xFF, 0x40, 0x50. Same entry with b3=0 -> 0x10, 0x40, 0x50.
- Flag 2 {0xAA, 0xBB}, out_ready low for 4 cycles after out_valid -> out_byte holds 0xAA with valid high; then 0xAA, 0xBB.
- Flag 5 run count 255, pushed each cycle with flag 1 entries, out_ready=1 -> after 8 queued entries the next push sets out_overflow; already queued bytes emerge intact and in order.
- Flag 4 entry with in_flag_last=1 -> out_last high only with b4. With BS_BYTE_COUNT_EN, out_byte_count reads 4 and then clears.
- Reset asserted mid-run -> outputs at reset values immediately. The first entry after release is emitted correctly.
